// File: rtl/week6_logic_pkg.sv
// Shared op codes and the bitwise evaluator for the week-6 logic pipe.
package week6_logic_pkg;

  localparam int MAX_W = 64;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_BUF  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  // Evaluated at MAX_W; callers truncate to their own width.
  function automatic logic [MAX_W-1:0] logic_eval(input logic [2:0] op,
                                                  input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
    case (op)
      OP_NOT:  logic_eval = ~a;
      OP_BUF:  logic_eval = a;
      OP_AND:  logic_eval = a & b;
      OP_OR:   logic_eval = a | b;
      OP_XOR:  logic_eval = a ^ b;
      OP_NAND: logic_eval = ~(a & b);
      OP_NOR:  logic_eval = ~(a | b);
      default: logic_eval = ~(a ^ b);
    endcase
  endfunction

endpackage

// File: rtl/week6_pipe_stage.sv
// One valid/data pipeline register: loads on ready, clears valid on flush.
module week6_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         rdy_nxt,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  output logic         rdy,
  output logic         out_v,
  output logic [W-1:0] out_d
);

  assign rdy = !out_v || rdy_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v <= 1'b0;
      out_d <= '0;
    end else if (flush) begin
      out_v <= 1'b0;
    end else if (rdy) begin
      out_v <= in_v;
      // Hold data across bubbles so the registers do not toggle needlessly.
      if (in_v) out_d <= in_d;
    end
  end

endmodule

// File: rtl/week6_logic_pipe.sv
// WIDTH-bit bitwise logic unit followed by a DEPTH-stage valid/ready pipeline.
// Optional parity sideband when LOGIC_PIPE_PARITY_EN is defined.
module week6_logic_pipe
  import week6_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
`ifdef LOGIC_PIPE_PARITY_EN
  input  logic             in_par_odd,
  output logic             out_par,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             busy
);

`ifdef LOGIC_PIPE_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  // Index 0 is the input side; index i+1 is the output of stage i.
  logic [DEPTH:0]         vld_pipe;
  logic [DEPTH:0][DW-1:0] dat_pipe;
  logic [DEPTH:0]         rdy;
  logic [WIDTH-1:0]       res;

  assign res = WIDTH'(logic_eval(in_op, MAX_W'(in_a), MAX_W'(in_b)));

`ifdef LOGIC_PIPE_PARITY_EN
  assign dat_pipe[0] = {(^res) ^ in_par_odd, res};
  assign out_par     = dat_pipe[DEPTH][WIDTH];
`else
  assign dat_pipe[0] = res;
`endif

  assign vld_pipe[0] = in_valid;
  assign rdy[DEPTH]  = out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    week6_pipe_stage #(.W(DW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .rdy_nxt (rdy[g+1]),
      .in_v    (vld_pipe[g]),
      .in_d    (dat_pipe[g]),
      .rdy     (rdy[g]),
      .out_v   (vld_pipe[g+1]),
      .out_d   (dat_pipe[g+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_pipe[DEPTH];
  assign out_y     = dat_pipe[DEPTH][WIDTH-1:0];
  assign busy      = |vld_pipe[DEPTH:1];

endmodule

// File: tb/tb_week6_logic_pipe.sv
// Randomised + directed bench for week6_logic_pipe against a queue-based model.
module tb_week6_logic_pipe;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         busy;
`ifdef LOGIC_PIPE_PARITY_EN
  logic         in_par_odd;
  logic         out_par;
  logic         w1_par;
`endif

  logic w1_valid, w1_a, w1_ready, w1_ov, w1_y, w1_busy;

  always #5 clk = ~clk;

  week6_logic_pipe #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
`ifdef LOGIC_PIPE_PARITY_EN
    .in_par_odd(in_par_odd), .out_par(out_par),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
  );

  week6_logic_pipe #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(w1_valid), .in_ready(w1_ready),
    .in_a(w1_a), .in_b(1'b0), .in_op(3'd0),
`ifdef LOGIC_PIPE_PARITY_EN
    .in_par_odd(1'b0), .out_par(w1_par),
`endif
    .out_valid(w1_ov), .out_ready(1'b1), .out_y(w1_y), .busy(w1_busy)
  );

  int checks = 0;
  int errors = 0;
  int n_edge = 0;

  typedef struct {
    logic [W-1:0] y;
    logic         p;
    int           t;
  } ent_t;

  ent_t         q[$];
  logic [W-1:0] got[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_y(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a & b);
      3'd6: return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  always @(posedge clk) n_edge++;

  // Model: queue of in-flight results; the oldest reaches the output D-1
  // edges after capture because nothing ahead of it can block it.
  logic exp_ov;
  ent_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_y", 32'(out_y), 32'd0);
    end else begin
      exp_ov = (q.size() > 0) && (n_edge - q[0].t >= D - 1);
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'((q.size() < D) || out_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("out_y", 32'(out_y), 32'(q[0].y));
`ifdef LOGIC_PIPE_PARITY_EN
        chk("out_par", 32'(out_par), 32'(q[0].p));
`endif
      end
      if (flush) begin
        q.delete();
      end else begin
        if (exp_ov && out_ready) begin
          got.push_back(out_y);
          void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          e.y = ref_y(in_op, in_a, in_b);
          e.p = ^e.y;
`ifdef LOGIC_PIPE_PARITY_EN
          e.p = e.p ^ in_par_odd;
`endif
          e.t = n_edge + 1;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic odd);
    int n;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
`ifdef LOGIC_PIPE_PARITY_EN
    in_par_odd = odd;
`else
    if (odd) ;
`endif
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_got", 32'(got.size() >= n), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ops_exp[7];
    logic [W-1:0] bp_exp[4];
    ops_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};
    bp_exp  = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b1; w1_valid = 1'b0; w1_a = 1'b0;
`ifdef LOGIC_PIPE_PARITY_EN
    in_par_odd = 1'b0;
`endif
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // NOT with latency check
    send(8'h5A, 8'h00, 3'd0, 1'b0);
    chk("not_lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("not_lat_valid", 32'(out_valid), 32'd1);
    chk("not_5a", 32'(out_y), 32'hA5);
    send(8'h00, 8'h00, 3'd0, 1'b0);
    @(posedge clk); #1;
    chk("not_00", 32'(out_y), 32'hFF);
    repeat (2) @(posedge clk); #1;

    // All ops back-to-back
    got.delete();
    send(8'hF0, 8'hCC, 3'd2, 1'b0);
    send(8'hF0, 8'hCC, 3'd3, 1'b0);
    send(8'hF0, 8'hCC, 3'd4, 1'b0);
    send(8'hF0, 8'hCC, 3'd5, 1'b0);
    send(8'hF0, 8'hCC, 3'd6, 1'b0);
    send(8'hF0, 8'hCC, 3'd7, 1'b0);
    send(8'hF0, 8'hCC, 3'd1, 1'b0);
    wait_got(7);
    for (int i = 0; i < 7; i++) chk($sformatf("ops_%0d", i), 32'(got[i]), 32'(ops_exp[i]));

    // Backpressure
    got.delete();
    out_ready = 1'b0;
    send(8'h01, 8'h00, 3'd0, 1'b0);
    send(8'h02, 8'h00, 3'd0, 1'b0);
    in_a = 8'h03; in_op = 3'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_y", 32'(out_y), 32'hFE);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h03, 8'h00, 3'd0, 1'b0);
    send(8'h04, 8'h00, 3'd0, 1'b0);
    wait_got(4);
    chk("bp_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_%0d", i), 32'(got[i]), 32'(bp_exp[i]));

    // Flush with two in flight plus an input in the flush cycle
    repeat (2) @(posedge clk); #1;
    got.delete();
    out_ready = 1'b0;
    send(8'h11, 8'h00, 3'd0, 1'b0);
    send(8'h22, 8'h00, 3'd0, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_a = 8'h33;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("flush_no_stale", 32'(got.size()), 32'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(8'h44, 8'h00, 3'd0, 1'b0);
    send(8'h55, 8'h00, 3'd0, 1'b0);
    in_valid = 1'b1; in_a = 8'h66;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_y", 32'(out_y), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    got.delete();
    send(8'h01, 8'h00, 3'd0, 1'b0);
    wait_got(1);
    chk("post_rst_not", 32'(got[0]), 32'hFE);

    // WIDTH=1, DEPTH=1 registered NOT
    w1_a = 1'b0; w1_valid = 1'b1;
    @(posedge clk); #1;
    chk("w1_ov0", 32'(w1_ov), 32'd1);
    chk("w1_not0", 32'(w1_y), 32'd1);
    w1_a = 1'b1;
    @(posedge clk); #1;
    w1_valid = 1'b0;
    chk("w1_ov1", 32'(w1_ov), 32'd1);
    chk("w1_not1", 32'(w1_y), 32'd0);
    @(posedge clk); #1;
    chk("w1_idle", 32'(w1_ov), 32'd0);

`ifdef LOGIC_PIPE_PARITY_EN
    send(8'h07, 8'h00, 3'd0, 1'b0);
    @(posedge clk); #1;
    chk("par_even", 32'(out_par), 32'd1);
    send(8'h07, 8'h00, 3'd0, 1'b1);
    @(posedge clk); #1;
    chk("par_odd", 32'(out_par), 32'd0);
`endif

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_op     = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
`ifdef LOGIC_PIPE_PARITY_EN
      in_par_odd = 1'($urandom_range(0, 1));
`endif
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (D + 3) @(posedge clk);
    #1;
    chk("drain_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
